// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared state and mode encodings for the frequency meter
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_SINGLE  = 2'b01;
  localparam logic [1:0] MODE_INHIBIT = 2'b11;

endpackage

// File: rtl/gated_period_counter_if.sv
// rtl/gated_period_counter_if.sv - control/result bundle of the gate-window counter
interface gated_period_counter_if #(
  parameter int W = 16
);

  logic         Clear;
  logic         En;
  logic         Store;
  logic [1:0]   Status_Value;
  logic [W-1:0] Q;
  logic [W-1:0] Count;
  logic         Valid;
  logic         Ovf;
  logic         unable;

  modport master (
    output Clear, En, Store, Status_Value,
    input  Q, Count, Valid, Ovf, unable
  );

  modport slave (
    input  Clear, En, Store, Status_Value,
    output Q, Count, Valid, Ovf, unable
  );

endinterface

// File: rtl/gate_edge_det.sv
// rtl/gate_edge_det.sv - registers the gate level and flags its rising/falling edges
module gate_edge_det (
  input  logic CP,
  input  logic RST,
  input  logic Clear,
  input  logic En,
  output logic rise,
  output logic fall
);

  logic en_d;

  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      en_d <= 1'b0;
    end else if (!Clear) begin
      en_d <= 1'b0;
    end else begin
      en_d <= En;
    end
  end

  assign rise = En & ~en_d;
  assign fall = ~En & en_d;

endmodule

// File: rtl/gated_period_counter.sv
// rtl/gated_period_counter.sv - counts CP edges over NWIN gate windows and latches the total
// GPC_SATURATE_EN selects saturating (defined) or wrapping (undefined) accumulation.
module gated_period_counter
  import freq_meter_pkg::*;
#(
  parameter int W    = 16,
  parameter int NWIN = 1
) (
  input logic                  CP,
  input logic                  RST,
  gated_period_counter_if.slave gp
);

  localparam logic [7:0]   WIN_LAST = 8'(NWIN - 1);
  localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

  state_t       state, state_nxt;
  logic [W-1:0] count_r, count_nxt, q_r, q_nxt, count_inc;
  logic [7:0]   win_r, win_nxt;
  logic         ovf_i, ovf_i_nxt, ovf_r, ovf_nxt, valid_r, valid_nxt;
  logic         inc_ovf, rise, fall;

  gate_edge_det u_edge (
    .CP    (CP),
    .RST   (RST),
    .Clear (gp.Clear),
    .En    (gp.En),
    .rise  (rise),
    .fall  (fall)
  );

  always_comb begin
    inc_ovf = &count_r;
`ifdef GPC_SATURATE_EN
    count_inc = inc_ovf ? count_r : count_r + CNT_ONE;
`else
    count_inc = count_r + CNT_ONE;
`endif
  end

  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      count_r <= '0;
      win_r   <= '0;
      ovf_i   <= 1'b0;
      q_r     <= '0;
      ovf_r   <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      count_r <= count_nxt;
      win_r   <= win_nxt;
      ovf_i   <= ovf_i_nxt;
      q_r     <= q_nxt;
      ovf_r   <= ovf_nxt;
      valid_r <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count_r;
    win_nxt   = win_r;
    ovf_i_nxt = ovf_i;
    q_nxt     = q_r;
    ovf_nxt   = ovf_r;
    valid_nxt = 1'b0;
    if (!gp.Clear) begin
      state_nxt = IDLE;
      count_nxt = '0;
      win_nxt   = '0;
      ovf_i_nxt = 1'b0;
      q_nxt     = '0;
      ovf_nxt   = 1'b0;
    end else if (gp.Status_Value == MODE_INHIBIT) begin
      // Aborted measurement is discarded; the last published result survives.
      state_nxt = IDLE;
      count_nxt = '0;
      win_nxt   = '0;
      ovf_i_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!gp.En && (gp.Status_Value != MODE_SINGLE || gp.Store)) begin
            state_nxt = ARMED;
          end
        end
        ARMED: begin
          if (rise) begin
            count_nxt = count_inc;
            ovf_i_nxt = ovf_i | inc_ovf;
            state_nxt = COUNT;
          end
        end
        COUNT: begin
          if (fall) begin
            if (win_r == WIN_LAST) begin
              state_nxt = DONE;
            end else begin
              win_nxt   = win_r + 8'd1;
              state_nxt = ARMED;
            end
          end else if (gp.En) begin
            count_nxt = count_inc;
            ovf_i_nxt = ovf_i | inc_ovf;
          end
        end
        DONE: begin
          q_nxt     = count_r;
          ovf_nxt   = ovf_i;
          valid_nxt = 1'b1;
          count_nxt = '0;
          win_nxt   = '0;
          ovf_i_nxt = 1'b0;
          state_nxt = (gp.Status_Value == MODE_SINGLE) ? IDLE : ARMED;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign gp.Q      = q_r;
  assign gp.Count  = count_r;
  assign gp.Valid  = valid_r;
  assign gp.Ovf    = ovf_r;
  assign gp.unable = (state == IDLE);

endmodule

// File: tb/tb_gated_period_counter.sv
// tb/tb_gated_period_counter.sv - scoreboard bench over three counter configurations
module tb_gated_period_counter;

  typedef struct {
    logic [15:0] q;
    logic        ovf;
  } exp_t;

  logic       cp = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b1;
  logic       en = 1'b0;
  logic       store = 1'b0;
  logic [1:0] status = 2'b00;

  int   checks = 0;
  int   errors = 0;
  int   active = 0;
  int   nvalid = 0;
  exp_t sb[$];

  logic [15:0] q_w[3];
  logic [15:0] count_w[3];
  logic        valid_w[3];
  logic        ovf_w[3];
  logic        unable_w[3];

  always #5 cp = ~cp;

  gated_period_counter_if #(.W(16)) if0 ();
  gated_period_counter_if #(.W(16)) if1 ();
  gated_period_counter_if #(.W(4))  if2 ();

  gated_period_counter #(.W(16), .NWIN(1)) u0 (.CP(cp), .RST(rst), .gp(if0.slave));
  gated_period_counter #(.W(16), .NWIN(3)) u1 (.CP(cp), .RST(rst), .gp(if1.slave));
  gated_period_counter #(.W(4),  .NWIN(1)) u2 (.CP(cp), .RST(rst), .gp(if2.slave));

  assign if0.Clear = clear;  assign if0.En = en;  assign if0.Store = store;  assign if0.Status_Value = status;
  assign if1.Clear = clear;  assign if1.En = en;  assign if1.Store = store;  assign if1.Status_Value = status;
  assign if2.Clear = clear;  assign if2.En = en;  assign if2.Store = store;  assign if2.Status_Value = status;

  assign q_w[0] = if0.Q;  assign count_w[0] = if0.Count;  assign valid_w[0] = if0.Valid;
  assign ovf_w[0] = if0.Ovf;  assign unable_w[0] = if0.unable;
  assign q_w[1] = if1.Q;  assign count_w[1] = if1.Count;  assign valid_w[1] = if1.Valid;
  assign ovf_w[1] = if1.Ovf;  assign unable_w[1] = if1.unable;
  assign q_w[2] = {12'd0, if2.Q};  assign count_w[2] = {12'd0, if2.Count};  assign valid_w[2] = if2.Valid;
  assign ovf_w[2] = if2.Ovf;  assign unable_w[2] = if2.unable;

  // Advance n cycles; every Valid on the active DUT consumes one scoreboard entry.
  task automatic tick(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge cp);
      if (valid_w[active]) begin
        nvalid++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid dut%0d: Valid=1 Q=%0d, required no Valid", active, q_w[active]);
        end else begin
          e = sb.pop_front();
          if (q_w[active] !== e.q || ovf_w[active] !== e.ovf) begin
            errors++;
            $display("FAIL result dut%0d: Q=%0d Ovf=%b, required Q=%0d Ovf=%b",
                     active, q_w[active], ovf_w[active], e.q, e.ovf);
          end
        end
      end
    end
  endtask

  task automatic push(input logic [15:0] q, input logic ovf);
    exp_t e;
    e.q = q;
    e.ovf = ovf;
    sb.push_back(e);
  endtask

  task automatic window(input int n);
    en = 1'b1;
    tick(n);
    en = 1'b0;
    tick(4);
  endtask

  task automatic drained(input string name);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drained: %0d results still pending, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset(input int dut, input logic [1:0] mode);
    active = dut;
    status = mode;
    en = 1'b0;
    store = 1'b0;
    clear = 1'b1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    sb.delete();
    nvalid = 0;
  endtask

  task automatic test_reset();
    active = 0;
    rst = 1'b1;
    tick(2);
    checks++;
    if (q_w[0] !== 16'd0 || count_w[0] !== 16'd0 || valid_w[0] !== 1'b0 ||
        ovf_w[0] !== 1'b0 || unable_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_values: Q=%0d Count=%0d Valid=%b Ovf=%b unable=%b, required 0 0 0 0 1",
               q_w[0], count_w[0], valid_w[0], ovf_w[0], unable_w[0]);
    end
  endtask

  task automatic test_single_window();
    do_reset(0, 2'b00);
    push(16'd100, 1'b0);
    en = 1'b1;
    tick(100);
    checks++;
    if (count_w[0] !== 16'd100) begin
      errors++;
      $display("FAIL live_count: Count=%0d, required 100", count_w[0]);
    end
    en = 1'b0;
    tick(5);
    checks++;
    if (nvalid != 1 || q_w[0] !== 16'd100 || unable_w[0] !== 1'b0 || count_w[0] !== 16'd0) begin
      errors++;
      $display("FAIL single_window: valids=%0d Q=%0d unable=%b Count=%0d, required 1 100 0 0",
               nvalid, q_w[0], unable_w[0], count_w[0]);
    end
    drained("single_window");
  endtask

  task automatic test_multi_window();
    do_reset(1, 2'b00);
    push(16'd60, 1'b0);
    window(10);
    window(20);
    checks++;
    if (nvalid != 0) begin
      errors++;
      $display("FAIL early_valid: valids=%0d after two windows, required 0", nvalid);
    end
    window(30);
    checks++;
    if (nvalid != 1 || q_w[1] !== 16'd60 || count_w[1] !== 16'd0) begin
      errors++;
      $display("FAIL multi_window: valids=%0d Q=%0d Count=%0d, required 1 60 0", nvalid, q_w[1], count_w[1]);
    end
    drained("multi_window");
  endtask

  task automatic test_overflow();
    logic [15:0] exp_q;
`ifdef GPC_SATURATE_EN
    exp_q = 16'd15;
`else
    exp_q = 16'd4;
`endif
    do_reset(2, 2'b00);
    push(16'd15, 1'b0);
    window(15);
    push(exp_q, 1'b1);
    window(20);
    checks++;
    if (ovf_w[2] !== 1'b1 || q_w[2] !== exp_q) begin
      errors++;
      $display("FAIL overflow: Ovf=%b Q=%0d, required Ovf=1 Q=%0d", ovf_w[2], q_w[2], exp_q);
    end
    drained("overflow");
  endtask

  task automatic test_single_shot();
    do_reset(0, 2'b01);
    checks++;
    if (unable_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL shot_idle: unable=%b before Store, required 1", unable_w[0]);
    end
    store = 1'b1;
    tick(1);
    store = 1'b0;
    push(16'd5, 1'b0);
    window(5);
    window(5);
    checks++;
    if (nvalid != 1 || q_w[0] !== 16'd5 || unable_w[0] !== 1'b1 || count_w[0] !== 16'd0) begin
      errors++;
      $display("FAIL single_shot: valids=%0d Q=%0d unable=%b Count=%0d, required 1 5 1 0",
               nvalid, q_w[0], unable_w[0], count_w[0]);
    end
    store = 1'b1;
    tick(1);
    store = 1'b0;
    push(16'd7, 1'b0);
    window(7);
    checks++;
    if (nvalid != 2 || q_w[0] !== 16'd7) begin
      errors++;
      $display("FAIL rearm: valids=%0d Q=%0d, required 2 7", nvalid, q_w[0]);
    end
    drained("single_shot");
  endtask

  task automatic test_inhibit();
    int v0;
    status = 2'b00;
    tick(2);
    en = 1'b1;
    tick(40);
    checks++;
    if (count_w[0] !== 16'd40) begin
      errors++;
      $display("FAIL pre_inhibit: Count=%0d, required 40", count_w[0]);
    end
    v0 = nvalid;
    status = 2'b11;
    tick(1);
    checks++;
    if (count_w[0] !== 16'd0 || unable_w[0] !== 1'b1 || q_w[0] !== 16'd7) begin
      errors++;
      $display("FAIL inhibit: Count=%0d unable=%b Q=%0d, required 0 1 7", count_w[0], unable_w[0], q_w[0]);
    end
    en = 1'b0;
    tick(4);
    checks++;
    if (nvalid != v0) begin
      errors++;
      $display("FAIL inhibit_valid: valids=%0d, required %0d", nvalid, v0);
    end
    status = 2'b00;
  endtask

  task automatic test_async_reset();
    nvalid = 0;
    tick(2);
    en = 1'b1;
    tick(10);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (q_w[0] !== 16'd0 || count_w[0] !== 16'd0 || valid_w[0] !== 1'b0 ||
        ovf_w[0] !== 1'b0 || unable_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: Q=%0d Count=%0d Valid=%b Ovf=%b unable=%b, required 0 0 0 0 1",
               q_w[0], count_w[0], valid_w[0], ovf_w[0], unable_w[0]);
    end
    tick(1);
    rst = 1'b0;
    tick(10);
    checks++;
    if (count_w[0] !== 16'd0 || unable_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL start_high: Count=%0d unable=%b, required 0 1", count_w[0], unable_w[0]);
    end
    en = 1'b0;
    tick(2);
    push(16'd8, 1'b0);
    window(8);
    checks++;
    if (nvalid != 1 || q_w[0] !== 16'd8) begin
      errors++;
      $display("FAIL after_reset: valids=%0d Q=%0d, required 1 8", nvalid, q_w[0]);
    end
    drained("after_reset");
  endtask

  initial begin
    test_reset();
    test_single_window();
    test_multi_window();
    test_overflow();
    test_single_shot();
    test_inhibit();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
